// File: rtl/commit_rob_pkg.sv
// Shared types for the commit reorder buffer.
//   exception_t        : exception record (cause, tval, valid)
//   scoreboard_entry_t : one in-flight instruction as seen by the commit stage
package commit_rob_pkg;

    localparam int unsigned XLEN          = 32;
    // Wide enough for any supported buffer depth; the slot index is zero-extended.
    localparam int unsigned TRANS_ID_BITS = 8;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    typedef struct packed {
        logic [XLEN-1:0]          pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [4:0]               rd;
        logic [XLEN-1:0]          result;
        logic                     valid;
        exception_t               ex;
    } scoreboard_entry_t;

endpackage

// File: rtl/commit_rob.sv
// Reorder buffer in front of the commit stage.
// Instructions are issued in order into the tail slot (trans_id = slot index), results and
// exceptions arrive out of order by trans_id, and the oldest NR_COMMIT_PORTS entries are
// presented to commit; an entry is valid once it is both issued and finished.
// Ports:
//   clk_i, rst_i (async, active-high), flush_i (sync discard of all entries)
//   issue_valid_i / issue_instr_i / issue_ready_o / issue_trans_id_o : enqueue at tail
//   wb_valid_i / wb_trans_id_i / wb_result_i / wb_ex_i              : per-port writeback
//   commit_instr_o / commit_ack_i                                   : head entries, retire
//   empty_o, usage_o                                                : occupancy
module commit_rob
    import commit_rob_pkg::*;
#(
    parameter int unsigned NR_ENTRIES      = 8,
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned NR_WB_PORTS     = 4,
    parameter int unsigned TIDW            = $clog2(NR_ENTRIES)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     flush_i,
    input  logic                                     issue_valid_i,
    input  scoreboard_entry_t                        issue_instr_i,
    output logic                                     issue_ready_o,
    output logic [TIDW-1:0]                          issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0]                   wb_valid_i,
    input  logic [NR_WB_PORTS-1:0][TIDW-1:0]         wb_trans_id_i,
    input  logic [NR_WB_PORTS-1:0][XLEN-1:0]         wb_result_i,
    input  exception_t [NR_WB_PORTS-1:0]             wb_ex_i,
    output scoreboard_entry_t [NR_COMMIT_PORTS-1:0]  commit_instr_o,
    input  logic [NR_COMMIT_PORTS-1:0]               commit_ack_i,
    output logic                                     empty_o,
    output logic [TIDW:0]                            usage_o
);

    scoreboard_entry_t     mem_q [NR_ENTRIES];
    scoreboard_entry_t     mem_d [NR_ENTRIES];
    logic [NR_ENTRIES-1:0] issued_q, issued_d;
    logic [NR_ENTRIES-1:0] finished_q, finished_d;
    logic [TIDW-1:0]       head_q, head_d;
    logic [TIDW-1:0]       tail_q, tail_d;
    logic [TIDW:0]         count_q, count_d;
    logic                  issue_accept;

    assign issue_ready_o    = (count_q != (TIDW+1)'(NR_ENTRIES));
    assign issue_trans_id_o = tail_q;
    assign issue_accept     = issue_valid_i && issue_ready_o;
    assign empty_o          = (count_q == '0);
    assign usage_o          = count_q;

    always_comb begin : commit_out
        logic [TIDW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            idx                        = head_q + TIDW'(i);
            commit_instr_o[i]          = mem_q[idx];
            commit_instr_o[i].valid    = issued_q[idx] && finished_q[idx];
            commit_instr_o[i].trans_id = TRANS_ID_BITS'(idx);
        end
    end

    always_comb begin : next_state
        logic [TIDW-1:0] idx;
        logic [TIDW:0]   retired;
        logic            chain;
        mem_d      = mem_q;
        issued_d   = issued_q;
        finished_d = finished_q;
        tail_d     = tail_q;
        idx        = '0;
        retired    = '0;
        chain      = 1'b1;

        if (issue_accept) begin
            mem_d[tail_q]          = issue_instr_i;
            mem_d[tail_q].trans_id = TRANS_ID_BITS'(tail_q);
            issued_d[tail_q]       = 1'b1;
            // A pre-faulted instruction needs no writeback before it can commit.
            finished_d[tail_q]     = issue_instr_i.ex.valid;
            tail_d                 = tail_q + TIDW'(1);
        end

        // Ascending port order: the highest-numbered port wins on a slot collision.
        for (int p = 0; p < NR_WB_PORTS; p++) begin
            if (wb_valid_i[p] && issued_q[wb_trans_id_i[p]]) begin
                mem_d[wb_trans_id_i[p]].result = wb_result_i[p];
                finished_d[wb_trans_id_i[p]]   = 1'b1;
                if (wb_ex_i[p].valid) begin
                    mem_d[wb_trans_id_i[p]].ex = wb_ex_i[p];
                end
            end
        end

        // Retire in order: a port only retires if all older ports retire this cycle.
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            idx   = head_q + TIDW'(i);
            chain = chain && commit_ack_i[i] && commit_instr_o[i].valid;
            if (chain) begin
                issued_d[idx]   = 1'b0;
                finished_d[idx] = 1'b0;
                retired         = retired + (TIDW+1)'(1);
            end
        end

        head_d  = head_q + TIDW'(retired);
        count_d = count_q + (TIDW+1)'(issue_accept) - retired;

        if (flush_i) begin
            issued_d   = '0;
            finished_d = '0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q      <= '{default: '0};
            issued_q   <= '0;
            finished_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            mem_q      <= mem_d;
            issued_q   <= issued_d;
            finished_q <= finished_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_commit_rob.sv
// Self-checking bench for commit_rob: a trans_id queue records issue order, small per-slot
// arrays hold the expected result/exception, and commit outputs are compared in order.
module tb_commit_rob;
    import commit_rob_pkg::*;

    logic                    clk;
    logic                    rst;
    logic                    flush;
    logic                    issue_valid;
    scoreboard_entry_t       issue_instr;
    logic                    issue_ready;
    logic [2:0]              issue_tid;
    logic [3:0]              wb_valid;
    logic [3:0][2:0]         wb_tid;
    logic [3:0][XLEN-1:0]    wb_res;
    exception_t [3:0]        wb_ex;
    scoreboard_entry_t [1:0] commit_instr;
    logic [1:0]              ack;
    logic                    empty;
    logic [3:0]              usage;

    int total;
    int bad;

    // Model state
    int          exp_q[$];
    int          tb_tail;
    int          tb_count;
    logic [31:0] m_res   [8];
    logic [31:0] m_cause [8];
    logic        m_exv   [8];
    logic        m_fin   [8];
    logic        m_iss   [8];

    commit_rob dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .flush_i          (flush),
        .issue_valid_i    (issue_valid),
        .issue_instr_i    (issue_instr),
        .issue_ready_o    (issue_ready),
        .issue_trans_id_o (issue_tid),
        .wb_valid_i       (wb_valid),
        .wb_trans_id_i    (wb_tid),
        .wb_result_i      (wb_res),
        .wb_ex_i          (wb_ex),
        .commit_instr_o   (commit_instr),
        .commit_ack_i     (ack),
        .empty_o          (empty),
        .usage_o          (usage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol monitors: the stimulus below must never trip these.
    always @(posedge clk) begin
        if (!rst) begin
            for (int p = 0; p < 4; p++)
                for (int q = p + 1; q < 4; q++)
                    if (wb_valid[p] && wb_valid[q] && wb_tid[p] == wb_tid[q])
                        $error("writeback collision on slot %0d", wb_tid[p]);
            if (ack[1] && !ack[0]) $error("ack[1] without ack[0]");
            for (int i = 0; i < 2; i++)
                if (ack[i] && !commit_instr[i].valid) $error("ack on invalid entry %0d", i);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        tb_tail  = 0;
        tb_count = 0;
        exp_q.delete();
        for (int s = 0; s < 8; s++) begin
            m_res[s] = '0; m_cause[s] = '0; m_exv[s] = 1'b0; m_fin[s] = 1'b0; m_iss[s] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_usage"}, 64'(usage), 64'(tb_count));
        chk({tag, "_empty"}, 64'(empty), 64'(tb_count == 0));
        chk({tag, "_ready"}, 64'(issue_ready), 64'(tb_count != 8));
        for (int i = 0; i < 2; i++)
            chk($sformatf("%s_valid%0d", tag, i), 64'(commit_instr[i].valid),
                64'((i < exp_q.size()) ? m_fin[exp_q[i]] : 1'b0));
    endtask

    task automatic do_issue(input logic exv, input logic [31:0] cause);
        chk("issue_ready", 64'(issue_ready), 64'd1);
        chk("issue_tid", 64'(issue_tid), 64'(tb_tail));
        issue_instr          = '0;
        issue_instr.pc       = 32'h1000 + 32'(tb_tail * 4);
        issue_instr.ex.valid = exv;
        issue_instr.ex.cause = cause;
        issue_valid          = 1'b1;
        step();
        issue_valid          = 1'b0;
        m_res[tb_tail]   = '0;
        m_exv[tb_tail]   = exv;
        m_cause[tb_tail] = cause;
        m_fin[tb_tail]   = exv;
        m_iss[tb_tail]   = 1'b1;
        exp_q.push_back(tb_tail);
        tb_tail  = (tb_tail + 1) % 8;
        tb_count = tb_count + 1;
    endtask

    task automatic do_wb(input int port, input int slot, input logic [31:0] data,
                         input logic exv, input logic [31:0] cause);
        exception_t e;
        e            = '0;
        e.valid      = exv;
        e.cause      = cause;
        wb_valid     = '0;
        wb_valid[port] = 1'b1;
        wb_tid[port] = 3'(slot);
        wb_res[port] = data;
        wb_ex[port]  = e;
        step();
        wb_valid     = '0;
        if (m_iss[slot]) begin
            m_res[slot] = data;
            m_fin[slot] = 1'b1;
            if (exv) begin
                m_exv[slot]   = 1'b1;
                m_cause[slot] = cause;
            end
        end
    endtask

    task automatic do_commit(input int n);
        int slot;
        for (int i = 0; i < n; i++) begin
            slot = exp_q[i];
            chk($sformatf("c%0d_valid", i), 64'(commit_instr[i].valid), 64'd1);
            chk($sformatf("c%0d_tid", i), 64'(commit_instr[i].trans_id), 64'(slot));
            chk($sformatf("c%0d_result", i), 64'(commit_instr[i].result), 64'(m_res[slot]));
            chk($sformatf("c%0d_exv", i), 64'(commit_instr[i].ex.valid), 64'(m_exv[slot]));
            chk($sformatf("c%0d_cause", i), 64'(commit_instr[i].ex.cause), 64'(m_cause[slot]));
        end
        ack = (n == 2) ? 2'b11 : 2'b01;
        step();
        ack = 2'b00;
        for (int i = 0; i < n; i++) begin
            slot = exp_q.pop_front();
            m_iss[slot] = 1'b0;
            m_fin[slot] = 1'b0;
        end
        tb_count = tb_count - n;
        chk("commit_usage", 64'(usage), 64'(tb_count));
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        flush       = 1'b0;
        issue_valid = 1'b0;
        issue_instr = '0;
        wb_valid    = '0;
        wb_tid      = '0;
        wb_res      = '0;
        wb_ex       = '0;
        ack         = 2'b00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk_state("reset");
        chk("reset_tid", 64'(issue_tid), 64'd0);

        // Fill without writeback
        for (int i = 0; i < 8; i++) do_issue(1'b0, '0);
        chk_state("full");
        chk("full_ready", 64'(issue_ready), 64'd0);

        // Out-of-order writeback, then dual commit
        do_wb(1, 1, 32'hAA, 1'b0, '0);
        do_wb(0, 0, 32'h55, 1'b0, '0);
        chk("wb_res0", 64'(commit_instr[0].result), 64'h55);
        chk("wb_res1", 64'(commit_instr[1].result), 64'hAA);
        do_commit(2);
        chk("after_ack_usage", 64'(usage), 64'd6);

        // Wrap-around
        do_reset();
        for (int i = 0; i < 8; i++) do_issue(1'b0, '0);
        for (int s = 0; s < 3; s++) do_wb(s, s, 32'h100 + 32'(s), 1'b0, '0);
        do_commit(2);
        do_commit(1);
        for (int i = 0; i < 3; i++) do_issue(1'b0, '0);
        chk_state("wrapped");
        for (int k = 0; k < 8; k++) do_wb(k % 4, (k + 3) % 8, 32'h200 + 32'(k), 1'b0, '0);
        for (int k = 0; k < 4; k++) do_commit(2);
        chk_state("drained");

        // Full buffer: ack and issue in the same cycle, issue must be rejected
        for (int i = 0; i < 8; i++) do_issue(1'b0, '0);
        do_wb(3, exp_q[0], 32'h333, 1'b0, '0);
        chk("nobypass_ready", 64'(issue_ready), 64'd0);
        issue_instr = '0;
        issue_valid = 1'b1;
        ack         = 2'b01;
        step();
        issue_valid = 1'b0;
        ack         = 2'b00;
        begin
            int slot;
            slot = exp_q.pop_front();
            m_iss[slot] = 1'b0;
            m_fin[slot] = 1'b0;
        end
        tb_count = tb_count - 1;
        chk("nobypass_usage", 64'(usage), 64'd7);
        do_issue(1'b0, '0);
        chk("refill_usage", 64'(usage), 64'd8);

        // Pre-faulted issue and writeback exception
        do_reset();
        do_issue(1'b1, 32'd12);
        chk("prefault_valid", 64'(commit_instr[0].valid), 64'd1);
        chk("prefault_cause", 64'(commit_instr[0].ex.cause), 64'd12);
        do_issue(1'b0, '0);
        do_wb(2, 1, 32'h77, 1'b1, 32'd5);
        chk("wbex_cause1", 64'(commit_instr[1].ex.cause), 64'd5);
        chk("wbex_cause0", 64'(commit_instr[0].ex.cause), 64'd12);
        do_commit(2);

        // Flush with same-cycle issue and writeback
        do_reset();
        for (int i = 0; i < 5; i++) do_issue(1'b0, '0);
        flush       = 1'b1;
        issue_instr = '0;
        issue_valid = 1'b1;
        wb_valid    = 4'b0001;
        wb_tid[0]   = 3'd0;
        wb_res[0]   = 32'hDEAD;
        wb_ex[0]    = '0;
        step();
        flush       = 1'b0;
        issue_valid = 1'b0;
        wb_valid    = '0;
        model_reset();
        chk_state("flush");
        do_issue(1'b0, '0);

        // Asynchronous reset mid-fill
        do_reset();
        for (int i = 0; i < 3; i++) do_issue(1'b0, '0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk_state("async_rst");
        chk("async_rst_tid", 64'(issue_tid), 64'd0);
        rst = 1'b0;
        step();
        do_issue(1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
